// File: rtl/spike_decoder.sv
// spike_decoder
//   Clocked consumer for the spiking network's output layer. Every 4-phase
//   request/acknowledge handshake from each output neuron is completed. The
//   block counts spikes per neuron over a programmable window of clock cycles.
//   It then scans the counts and reports the neuron with the highest count.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : asynchronous, active-low reset
//   req_out    : per-neuron spike requests (asynchronous to clk)
//   ack_out    : per-neuron acknowledges back to the output layer
//   start      : pulse that begins a classification window (accepted in IDLE only)
//   window_len : window length in cycles, sampled on an accepted start
//   busy       : high from an accepted start until done
//   done       : one-cycle pulse when winner/counts are valid
//   winner     : index of the neuron with the highest count (ties -> lowest index)
//   counts     : per-neuron saturating counts, neuron i at [i*cnt_size +: cnt_size]
module spike_decoder #(
  parameter  int neurons_out = 2,
  parameter  int cnt_size    = 8,
  parameter  int win_size    = 16,
  localparam int idx_size    = (neurons_out > 1) ? $clog2(neurons_out) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [neurons_out-1:0]          req_out,
  output logic [neurons_out-1:0]          ack_out,
  input  logic                            start,
  input  logic [win_size-1:0]             window_len,
  output logic                            busy,
  output logic                            done,
  output logic [idx_size-1:0]             winner,
  output logic [neurons_out*cnt_size-1:0] counts
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [cnt_size-1:0] CNT_MAX  = {cnt_size{1'b1}};
  localparam logic [idx_size-1:0] LAST_IDX = idx_size'(neurons_out - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [neurons_out-1:0]   r_sync1;
  logic [neurons_out-1:0]   r_sync2;
  logic [neurons_out-1:0]   r_ack;
  logic [neurons_out-1:0]   w_rise;
  logic [cnt_size-1:0]      r_count [neurons_out];
  logic [win_size-1:0]      r_timer;
  logic [idx_size-1:0]      r_scan_idx;
  logic [idx_size-1:0]      r_best_idx;
  logic [cnt_size-1:0]      r_best_cnt;
  logic [idx_size-1:0]      r_winner;
  logic                     r_busy;
  logic                     r_done;
  logic                     w_accept;

  assign w_accept = (r_state == ST_IDLE) && start;

  // The registered ack doubles as the channel state (0 = WAIT, 1 = ACKED), so
  // a WAIT->ACKED transition is exactly "synchronized req high, ack still low".
  assign w_rise = r_sync2 & ~r_ack;

  // Request synchronizers and per-channel handshake state; these run in every
  // top-level state so the network is never stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= {neurons_out{1'b0}};
      r_sync2 <= {neurons_out{1'b0}};
      r_ack   <= {neurons_out{1'b0}};
    end else begin
      r_sync1 <= req_out;
      r_sync2 <= r_sync1;
      r_ack   <= r_sync2;
    end
  end

  // Top FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Top FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          // A zero-length window skips counting entirely.
          if (window_len == {win_size{1'b0}}) begin
            w_state_nxt = ST_SCAN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_timer == win_size'(1)) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SCAN: begin
        if (r_scan_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-neuron saturating spike counters; cleared on an accepted start and
  // advanced only for acks that rise while the window is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < neurons_out; i++) begin
        r_count[i] <= {cnt_size{1'b0}};
      end
    end else begin
      for (int i = 0; i < neurons_out; i++) begin
        if (w_accept) begin
          r_count[i] <= {cnt_size{1'b0}};
        end else if ((r_state == ST_RUN) && w_rise[i] && (r_count[i] != CNT_MAX)) begin
          r_count[i] <= r_count[i] + cnt_size'(1);
        end else begin
          r_count[i] <= r_count[i];
        end
      end
    end
  end

  // Window timer, scan bookkeeping and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer    <= {win_size{1'b0}};
      r_scan_idx <= {idx_size{1'b0}};
      r_best_idx <= {idx_size{1'b0}};
      r_best_cnt <= {cnt_size{1'b0}};
      r_winner   <= {idx_size{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_timer    <= window_len;
            r_scan_idx <= {idx_size{1'b0}};
            r_best_idx <= {idx_size{1'b0}};
            r_best_cnt <= {cnt_size{1'b0}};
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_timer <= r_timer - win_size'(1);
        end
        ST_SCAN: begin
          // Strict comparison keeps the lowest index on ties.
          if (r_count[r_scan_idx] > r_best_cnt) begin
            r_best_idx <= r_scan_idx;
            r_best_cnt <= r_count[r_scan_idx];
          end
          r_scan_idx <= r_scan_idx + idx_size'(1);
        end
        ST_DONE: begin
          r_done   <= 1'b1;
          r_winner <= r_best_idx;
          r_busy   <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign ack_out = r_ack;
  assign busy    = r_busy;
  assign done    = r_done;
  assign winner  = r_winner;

  for (genvar g = 0; g < neurons_out; g++) begin : g_pack
    assign counts[g*cnt_size +: cnt_size] = r_count[g];
  end

endmodule

// File: tb/tb_spike_decoder.sv
// Scoreboard bench for spike_decoder (4 channels, 4-bit counters).
// Stimulus tasks schedule spikes, derive expected window results and ack edge
// times from the timing rules, and push them into queues; independent monitor
// processes pop and compare whenever the DUT moves an ack or pulses done.
module tb_spike_decoder;

  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int WW  = 16;
  localparam int IW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      req_out = '0;
  logic [NCH-1:0]      ack_out;
  logic                start = 1'b0;
  logic [WW-1:0]       window_len = '0;
  logic                busy;
  logic                done;
  logic [IW-1:0]       winner;
  logic [NCH*CW-1:0]   counts;

  always #5 clk = ~clk;

  spike_decoder #(.neurons_out(NCH), .cnt_size(CW), .win_size(WW)) dut (
    .clk(clk), .rst(rst), .req_out(req_out), .ack_out(ack_out),
    .start(start), .window_len(window_len), .busy(busy), .done(done),
    .winner(winner), .counts(counts)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int                cyc;
    logic [NCH*CW-1:0] cnts;
    int                win;
  } res_t;

  res_t res_q[$];
  int   rise_q[NCH][$];
  int   fall_q[NCH][$];
  int   sq[NCH][$];          // spike drive offsets relative to the start cycle
  int   n_req  = 0;
  int   n_rise = 0;
  bit   mon_en = 1'b0;
  logic [NCH-1:0] prev_ack = '0;

  // Ack monitor: every ack edge must match the next expected edge time.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (ack_out[i] !== prev_ack[i]) begin
          if (ack_out[i] === 1'b1) begin
            n_rise++;
            check($sformatf("ack_rise_expected_ch%0d", i), rise_q[i].size() > 0, 1);
            if (rise_q[i].size() > 0) check($sformatf("ack_rise_cycle_ch%0d", i), cyc, rise_q[i].pop_front());
          end else begin
            check($sformatf("ack_fall_expected_ch%0d", i), fall_q[i].size() > 0, 1);
            if (fall_q[i].size() > 0) check($sformatf("ack_fall_cycle_ch%0d", i), cyc, fall_q[i].pop_front());
          end
        end
      end
    end
    prev_ack = ack_out;
  end

  // Result monitor: each done pulse is matched against the next expected window.
  initial forever begin
    @(negedge clk);
    if (mon_en && done === 1'b1) begin
      check("done_expected", res_q.size() > 0, 1);
      if (res_q.size() > 0) begin
        res_t r;
        r = res_q.pop_front();
        check("done_cycle", cyc, r.cyc);
        check("counts", counts, r.cnts);
        check("winner", winner, r.win);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic clear_sched();
    for (int i = 0; i < NCH; i++) sq[i].delete();
  endtask

  // Schedule reference: req of a spike driven at cycle d is high on negedges
  // d..d+3, so ack rises at edge d+3 and falls at edge d+7. A spike counts iff
  // its ack rises at one of the window edges s+1..s+W (s = start sample edge).
  task automatic run_window(input int W, input bit repulse);
    int a, s, last, end_c, bw, bc, n;
    logic [NCH*CW-1:0] ec;
    a = cyc;
    s = a + 1;
    last = a;
    bw = 0;
    bc = 0;
    ec = '0;
    for (int i = 0; i < NCH; i++) begin
      n = 0;
      foreach (sq[i][k]) begin
        int d;
        d = a + sq[i][k];
        if (d + 3 >= s + 1 && d + 3 <= s + W) n++;
        rise_q[i].push_back(d + 3);
        fall_q[i].push_back(d + 7);
        n_req++;
        if (d + 8 > last) last = d + 8;
      end
      if (n > 15) n = 15;
      ec[i*CW +: CW] = n[CW-1:0];
      if (n > bc) begin
        bc = n;
        bw = i;
      end
    end
    res_q.push_back('{a + W + NCH + 2, ec, bw});
    window_len = W[WW-1:0];
    end_c = (last > a + W + NCH + 4) ? last : a + W + NCH + 4;
    for (int c = a; c <= end_c; c++) begin
      start = (c == a) || (repulse && c == a + 5);
      if (c == a + 1) window_len = W[WW-1:0] ^ 16'h0005;
      for (int i = 0; i < NCH; i++) begin
        logic hi;
        hi = 1'b0;
        foreach (sq[i][k]) if (c >= a + sq[i][k] && c <= a + sq[i][k] + 3) hi = 1'b1;
        req_out[i] = hi;
      end
      if (c == a + 2) check("busy_after_start", busy, 1);
      @(negedge clk);
    end
    start = 1'b0;
    req_out = '0;
    repeat (3) @(negedge clk);
    check("window_result_consumed", res_q.size(), 0);
  endtask

  initial begin
    int r, W, t;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack_out, 0);
    check("rst_counts", counts, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_winner", winner, 0);

    // Reset in the middle of a window with every request held high.
    rst = 1'b1;
    @(negedge clk);
    window_len = 16'd50;
    start = 1'b1;
    req_out = 4'hF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_ack", ack_out, 4'hF);
    check("pre_reset_counts", counts, 16'h1111);
    check("pre_reset_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ack", ack_out, 0);
    check("async_rst_counts", counts, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    r = cyc;
    repeat (2) @(negedge clk);
    check("post_rst_ack_early", ack_out, 0);
    @(negedge clk);
    check("post_rst_ack_cycle", ack_out, 4'hF);
    check("post_rst_counts", counts, 0);
    req_out = '0;
    repeat (8) @(negedge clk);
    check("post_rst_ack_release", ack_out, 0);
    prev_ack = ack_out;
    mon_en = 1'b1;

    // Basic window: ch0 3 spikes, ch1 5 spikes.
    clear_sched();
    foreach (sq[0][k]) ;
    sq[0].push_back(10); sq[0].push_back(30); sq[0].push_back(50);
    for (int k = 0; k < 5; k++) sq[1].push_back(5 + 10 * k);
    run_window(100, 1'b0);

    // Tie 4/4 plus an out-of-window spike on ch3.
    clear_sched();
    for (int k = 0; k < 4; k++) begin
      sq[0].push_back(4 + 8 * k);
      sq[1].push_back(6 + 8 * k);
    end
    sq[3].push_back(70);
    run_window(60, 1'b0);

    // Empty window.
    clear_sched();
    run_window(30, 1'b0);

    // Saturation: 20 spikes on ch0.
    clear_sched();
    for (int k = 0; k < 20; k++) sq[0].push_back(2 + 8 * k);
    run_window(200, 1'b0);

    // Zero-length window with a spike that must not count.
    clear_sched();
    sq[1].push_back(0);
    run_window(0, 1'b0);

    // Last RUN edge counts, first SCAN edge does not; start re-pulsed in RUN.
    clear_sched();
    sq[2].push_back(18);
    sq[3].push_back(19);
    run_window(20, 1'b1);

    // Randomized windows on all channels.
    for (int w = 0; w < 12; w++) begin
      clear_sched();
      W = $urandom_range(0, 80);
      for (int i = 0; i < NCH; i++) begin
        t = $urandom_range(0, 6);
        while (t <= W + 12) begin
          if ($urandom_range(0, 3) != 0) sq[i].push_back(t);
          t += 8 + $urandom_range(0, 5);
        end
      end
      run_window(W, $urandom_range(0, 1) == 1);
    end

    repeat (10) @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("ack_rise_left_ch%0d", i), rise_q[i].size(), 0);
      check($sformatf("ack_fall_left_ch%0d", i), fall_q[i].size(), 0);
    end
    check("total_acks_vs_reqs", n_rise, n_req);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_decoder.md
# spike_decoder

Output-side responder for the asynchronous spiking network. It sits after the output layer, on that layer's request/acknowledge pair. It completes every 4-phase spike handshake from each output neuron and counts spikes per neuron over a programmable window of clock cycles. It then scans the counts and reports the winning neuron, which makes it the clocked consumer for the network's `req_out`/`ack_out` interface.

## Interface
- `neurons_out`, 2: number of output neurons / handshake channels (≥1)
- `cnt_size`, 8: spike counter width in bits
- `win_size`, 16: width of the window-length input
- `idx_size`, `$clog2(neurons_out)` (min 1): winner index width, derived

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_out`  in  neurons_out  spike requests from the output layer, asynchronous to `clk`
- `ack_out`  out  neurons_out  acknowledges to the output layer
- `start`  in  1  pulse that begins a classification window
- `window_len`  in  win_size  window length in cycles, sampled on an accepted `start`
- `busy`  out  1  high from an accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the result is valid
- `winner`  out  idx_size  index of the neuron with the highest count
- `counts`  out  neurons_out*cnt_size  per-neuron counts, neuron i at bits [i*cnt_size +: cnt_size]

## Operation
- Reset (`rst`=0): `ack_out`=0, `busy`=0, `done`=0, `winner`=0, `counts`=0, all synchronizers cleared, FSM in IDLE. Effect is immediate and asynchronous.
- Per channel i:
  - `req_out[i]` passes through a 2-flop synchronizer.
  - Channel FSM has states WAIT and ACKED.
  - WAIT → ACKED when the synchronized req is 1: set `ack_out[i]`=1.
  - ACKED → WAIT when the synchronized req is 0: clear `ack_out[i]`.
  - Handshakes complete in every top-level state, so the network never stalls.
- Counting:
  - `count[i]` increments on the WAIT→ACKED transition only while the top FSM is in RUN.
  - Counts saturate at 2^cnt_size−1 (no wrap).
  - Spikes outside RUN are acknowledged but not counted.
- Top FSM:
  - IDLE: on `start`=1, clear all counts, load timer=`window_len`, set `busy`=1. Go to RUN, or to SCAN if `window_len`=0.
  - RUN: timer decrements each cycle. RUN lasts exactly `window_len` cycles, then goes to SCAN. A spike accepted in the last RUN cycle is counted.
  - SCAN: takes neurons_out cycles. Index j runs 0..neurons_out−1. `best` updates when `count[j]` > `best_count` (strict comparison), so ties go to the lowest index. `best` is initialised to index 0, count 0.
  - DONE: one cycle. `done`=1, `winner`=`best`, `busy`=0. Then return to IDLE.
- `start` is ignored outside IDLE.
- `winner` and `counts` hold their values until the next accepted `start`. At that point `counts` clear and `winner` holds until the next DONE.
- If all counts are 0, `winner`=0.

## Timing
- Request to ack: when `req_out[i]` rises before edge k, `ack_out[i]` rises at edge k+2. Two synchronizer edges, then the registered ack.
- Release: `ack_out[i]` falls at edge k+2 after `req_out[i]` falls before edge k.
- A full handshake occupies ≥4 cycles. Requester obligations:
  - `req_out[i]` must not rise again until `ack_out[i]` is 0.
  - `req_out[i]` must not fall until `ack_out[i]` is 1.
- Count update occurs on the same edge as the ack rise.
- Start to done: `start` sampled at edge s. RUN spans edges s+1..s+`window_len`. SCAN spans the next neurons_out edges. `done` is high for the cycle after the last SCAN edge. Total latency from `start` to `done` = `window_len` + neurons_out + 1 cycles.
- Reset mid-window: everything clears and the FSM returns to IDLE. A `req_out` that is still high is re-acknowledged about 2 cycles after reset release and is not counted.
- Channels are independent. Simultaneous rises on multiple channels are all acknowledged and counted in the same cycle.

## Test plan
- Reset: assert `rst`=0 while `req_out`=2'b11 and ack is high → `ack_out`=0, `counts`=0, `busy`=0 immediately. After release, `ack_out`=2'b11 2 cycles later, counts remain 0.
- Basic window: `window_len`=100. Channel 0 spikes 3×, channel 1 spikes 5× inside the window → `counts`={5,3}, `winner`=1. `done` arrives exactly 103 cycles after `start`.
- Tie and empty: equal counts 4/4 → `winner`=0. No spikes → `winner`=0, `counts`=0.
- Saturation: `cnt_size`=4, 20 spikes on channel 0 → `count[0]`=15.
- Window edges:
  - `window_len`=0 → `done` after neurons_out+1 cycles with zero counts.
  - A spike acked in the last RUN cycle is counted; one acked in the first SCAN cycle is not.
  - `start` pulsed during RUN is ignored.
- Handshake timing: random `req_out` timing on 4 channels → ack rises and falls exactly 2 edges after the corresponding req edges. No ack is lost or duplicated, and total acks equal total requests.
